// File: rtl/vga_text_color_ctrl.sv
// Colour text-mode controller: VRAM of 16-bit cell descriptors, palette and cursor
// registers on an Avalon-MM slave, plus a 3-stage pixel pipeline driving an external font ROM.
module vga_text_color_ctrl #(
  parameter int COLS         = 80,
  parameter int ROWS         = 30,
  parameter int ADDR_W       = 11,
  parameter int PAL_ENTRIES  = 16,
  parameter int BLINK_FRAMES = 30
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              avl_read,
  input  logic              avl_write,
  input  logic              avl_cs,
  input  logic [3:0]        avl_byte_en,
  input  logic [ADDR_W-1:0] avl_addr,
  input  logic [31:0]       avl_writedata,
  output logic [31:0]       avl_readdata,
  input  logic [9:0]        pixel_x,
  input  logic [9:0]        pixel_y,
  input  logic              blank_in,
  input  logic              hs_in,
  input  logic              vs_in,
  output logic [10:0]       font_addr,
  input  logic [7:0]        font_data,
  output logic [3:0]        red,
  output logic [3:0]        green,
  output logic [3:0]        blue,
  output logic              hs,
  output logic              vs
);

  localparam int VRAM_WORDS = COLS * ROWS / 2;
  localparam int PAL_WORDS  = PAL_ENTRIES / 2;
  localparam int VA_W       = $clog2(VRAM_WORDS);
  localparam int PW_W       = (PAL_WORDS > 1) ? $clog2(PAL_WORDS) : 1;
  localparam int CNT_W      = $clog2(BLINK_FRAMES + 1);
  localparam logic [ADDR_W-1:0] PAL_BASE_A = ADDR_W'(VRAM_WORDS);
  localparam logic [ADDR_W-1:0] CTRL_A     = ADDR_W'(VRAM_WORDS + PAL_WORDS);

  logic [31:0] vram [VRAM_WORDS];
  logic [31:0] pal  [PAL_WORDS];
  logic [31:0] ctrl;

  function automatic logic [31:0] byte_merge(input logic [31:0] old_w, input logic [31:0] new_w,
                                             input logic [3:0] be);
    logic [31:0] r;
    r = old_w;
    for (int b = 0; b < 4; b++) if (be[b]) r[8*b +: 8] = new_w[8*b +: 8];
    return r;
  endfunction

  // Bus: a cycle with avl_cs&&avl_read is accepted at once (no wait states); avl_readdata
  // changes on the following edge and holds until the next accepted read. Read beats write.
  logic            bus_rd, bus_wr, in_vram, in_pal, in_ctrl;
  logic [PW_W-1:0] pal_off;

  assign bus_rd  = avl_cs && avl_read;
  assign bus_wr  = avl_cs && avl_write && !avl_read;
  assign in_vram = avl_addr < PAL_BASE_A;
  assign in_pal  = (avl_addr >= PAL_BASE_A) && (avl_addr < CTRL_A);
  assign in_ctrl = avl_addr == CTRL_A;
  assign pal_off = PW_W'(avl_addr - PAL_BASE_A);

  always_ff @(posedge clk) begin
    if (bus_wr && in_vram) begin
      for (int b = 0; b < 4; b++)
        if (avl_byte_en[b]) vram[avl_addr[VA_W-1:0]][8*b +: 8] <= avl_writedata[8*b +: 8];
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      avl_readdata <= '0;
      ctrl         <= '0;
      for (int i = 0; i < PAL_WORDS; i++) pal[i] <= '0;
    end else if (bus_rd) begin
      if (in_vram)      avl_readdata <= vram[avl_addr[VA_W-1:0]];
      else if (in_pal)  avl_readdata <= pal[pal_off];
      else if (in_ctrl) avl_readdata <= ctrl;
      else              avl_readdata <= '0;
    end else if (bus_wr) begin
      if (in_pal)  pal[pal_off] <= byte_merge(pal[pal_off], avl_writedata, avl_byte_en);
      if (in_ctrl) ctrl         <= byte_merge(ctrl, avl_writedata, avl_byte_en);
    end
  end

  // Frame-based cursor blink, advanced on each falling edge of vs_in.
  logic             vs_prev, phase;
  logic [CNT_W-1:0] frame_cnt;

  always_ff @(posedge clk) begin
    if (reset) begin
      vs_prev   <= 1'b1;
      frame_cnt <= '0;
      phase     <= 1'b1;
    end else begin
      vs_prev <= vs_in;
      if (vs_prev && !vs_in) begin
        if (frame_cnt == CNT_W'(BLINK_FRAMES - 1)) begin
          frame_cnt <= '0;
          phase     <= ~phase;
        end else begin
          frame_cnt <= frame_cnt + 1'b1;
        end
      end
    end
  end

  // S0: cell fetch and cursor match.
  logic [6:0]      col;
  logic [5:0]      row;
  logic            ok0, cur0;
  logic [VA_W-1:0] word_b;
  logic [31:0]     vram_b_q;

  assign col    = pixel_x[9:3];
  assign row    = pixel_y[9:4];
  assign ok0    = (int'(col) < COLS) && (int'(row) < ROWS);
  assign word_b = ok0 ? VA_W'((int'(row) * COLS + int'(col)) >> 1) : '0;
  assign cur0   = ctrl[16] && ({1'b0, col} == ctrl[7:0]) && ({2'b0, row} == ctrl[15:8]) &&
                  (pixel_y[3:0] >= 4'd14) && (!ctrl[17] || phase);

  always_ff @(posedge clk) vram_b_q <= vram[word_b];

  logic       s1_half, s1_cur, s1_ok, s1_blank, s1_hs, s1_vs;
  logic [2:0] s1_x;
  logic [3:0] s1_grow;

  always_ff @(posedge clk) begin
    if (reset) begin
      {s1_half, s1_cur, s1_ok, s1_x, s1_grow} <= '0;
      s1_blank <= 1'b0;
      s1_hs    <= 1'b1;
      s1_vs    <= 1'b1;
    end else begin
      s1_half  <= col[0];
      s1_cur   <= cur0;
      s1_ok    <= ok0;
      s1_x     <= pixel_x[2:0];
      s1_grow  <= pixel_y[3:0];
      s1_blank <= blank_in;
      s1_hs    <= hs_in;
      s1_vs    <= vs_in;
    end
  end

  // S1: pick the descriptor half and address the font ROM.
  logic [15:0] desc;
  assign desc      = s1_half ? vram_b_q[31:16] : vram_b_q[15:0];
  assign font_addr = {desc[14:8], s1_grow};

  logic       s2_inv, s2_cur, s2_ok, s2_blank, s2_hs, s2_vs;
  logic [3:0] s2_fg, s2_bg;
  logic [2:0] s2_x;

  always_ff @(posedge clk) begin
    if (reset) begin
      {s2_inv, s2_cur, s2_ok, s2_fg, s2_bg, s2_x} <= '0;
      s2_blank <= 1'b0;
      s2_hs    <= 1'b1;
      s2_vs    <= 1'b1;
    end else begin
      s2_inv   <= desc[15];
      s2_cur   <= s1_cur;
      s2_ok    <= s1_ok;
      s2_fg    <= desc[7:4];
      s2_bg    <= desc[3:0];
      s2_x     <= s1_x;
      s2_blank <= s1_blank;
      s2_hs    <= s1_hs;
      s2_vs    <= s1_vs;
    end
  end

  // S2: font bit, invert, cursor override, palette lookup.
  logic            pix_on;
  logic [3:0]      pix_idx;
  logic [PW_W-1:0] pal_sel;
  logic [31:0]     pal_w;
  logic [11:0]     color;

  assign pix_on  = (font_data[~s2_x] ^ s2_inv) || s2_cur;
  assign pix_idx = pix_on ? s2_fg : s2_bg;
  assign pal_sel = PW_W'(pix_idx >> 1);
  assign pal_w   = pal[pal_sel];
  assign color   = pix_idx[0] ? pal_w[24:13] : pal_w[12:1];

  logic [11:0] rgb_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      rgb_q <= '0;
      hs    <= 1'b1;
      vs    <= 1'b1;
    end else begin
      rgb_q <= (s2_blank && s2_ok && (int'(pix_idx) < PAL_ENTRIES)) ? color : 12'h000;
      hs    <= s2_hs;
      vs    <= s2_vs;
    end
  end

  assign {red, green, blue} = rgb_q;

endmodule

// File: doc/vga_text_color_ctrl.md
Name: vga_text_color_ctrl

Overview:
Parametrised colour text-mode controller: COLS x ROWS cells of 8x16 glyphs. Each cell has a 16-bit descriptor holding glyph, invert bit and per-cell fg/bg palette indices.
Sits on the Avalon-MM bus as a slave with registered, 1-cycle read latency. Consumes pixel coordinates and sync from the existing VGA timing generator and drives an external synchronous font ROM.
Adds a hardware cursor with frame-based blink. RGB output is pipelined, with sync re-aligned to match.

Parameters:
COLS, 80, character columns (even)
ROWS, 30, character rows
ADDR_W, 11, Avalon word-address width; must cover VRAM_WORDS+PAL_WORDS+1
PAL_ENTRIES, 16, palette colours (12-bit RGB), two per word
BLINK_FRAMES, 30, frames per cursor blink half-period
(derived) VRAM_WORDS = COLS*ROWS/2; PAL_BASE = VRAM_WORDS; PAL_WORDS = PAL_ENTRIES/2; CTRL_ADDR = PAL_BASE+PAL_WORDS

Ports:
clk  in  1  pixel/bus clock
reset  in  1  synchronous, active-high
avl_read  in  1  Avalon read strobe
avl_write  in  1  Avalon write strobe
avl_cs  in  1  chip select
avl_byte_en  in  4  write byte enables
avl_addr  in  ADDR_W  word address
avl_writedata  in  32  write data
avl_readdata  out  32  read data, valid 1 cycle after read accepted
pixel_x  in  10  current pixel column from timing generator
pixel_y  in  10  current pixel row
blank_in  in  1  1 = active video
hs_in, vs_in  in  1 each  active-low sync from timing generator
font_addr  out  11  {glyph[6:0], glyph_row[3:0]} to font ROM
font_data  in  8  glyph row, 1-cycle latency, bit7 = leftmost pixel
red, green, blue  out  4 each  pixel colour
hs, vs  out  1 each  sync delayed to align with RGB

Behaviour:
- Reset is synchronous, active-high, on clock clk.
- Cell descriptor: [15] invert, [14:8] glyph, [7:4] fg index, [3:0] bg index. Even cell in word bits [15:0], odd cell in [31:16]. Cell n = row*COLS+col lives at word n>>1.
- VRAM: dual-port block RAM, not cleared by reset. Port A serves the bus, port B the display.
- Palette word k: [12:1] colour 2k, [24:13] colour 2k+1, as {R,G,B} 4 bits each; other bits read back as written.
- CTRL register: [7:0] cursor col, [15:8] cursor row, [16] cursor enable, [17] blink enable.
- Writes: byte-enable masked; addresses >= CTRL_ADDR+1 ignored.
- Reads: avl_readdata updated the cycle after avl_cs&&avl_read and held until the next read. Out-of-range returns 0. read&&write together: read wins, no write.
- Display pipeline, latency 3 cycles:
  S0: char index from pixel_x[9:3], pixel_y[9:4]; VRAM port B read.
  S1: select half by col[0]; drive font_addr; register attributes and pixel_x[2:0].
  S2: pick font bit ~x[2:0]; pixel = bit ^ invert; cursor override; palette lookup.
  S3: register RGB.
- hs, vs and blank are delayed through 3 matching stages.
- Cursor: cell matches CTRL col/row, enable=1, glyph_row >= 14, and (blink_en=0 or phase=1) -> fg colour.
- Blink: frame counter increments on each vs_in falling edge. At BLINK_FRAMES-1 it wraps to 0 and toggles phase.
- Cells with col >= COLS or row >= ROWS output black.
- Delayed blank=0 -> RGB 0.
- Reset values: avl_readdata=0, palette=0, CTRL=0, RGB=0, hs=vs=1, delay stages hold blank=0 and hs=vs=1, frame counter=0, phase=1.
- Reset mid-frame: output black, syncs inactive until the pipeline refills (3 cycles after reset deasserts).
- A bus write to a cell takes effect on display from the next fetch of that cell. No stall or arbitration between ports.

Test Plan:
- Reset: assert reset 2 cycles mid-line -> RGB=0, hs=vs=1, readdata=0. After release, syncs follow inputs with 3-cycle delay.
- Bus: write 0xDEADBEEF to word 5 with byte_en=0b0101, then read -> readdata=0x00AD00EF exactly 1 cycle after the read strobe. Read of CTRL_ADDR+1 -> 0.
- Colour pixel:
  - Setup: palette word 0 = 0x01FFE000 (c0=0x000, c1=0xFFF). Cell (0,0) = 0x4110 (glyph 0x41, fg 1, bg 0). font_data for row 3 = 0x80.
  - Stimulus: pixel (0,3) then (1,3).
  - Expect: RGB 0xFFF then 0x000, each 3 cycles after input.
- Invert: set bit15 on the same cell -> pixel (0,3) gives 0x000, (1,3) gives 0xFFF.
- Odd cell and bounds: cell (1,0) in word 0 bits [31:16] renders at pixel_x 8..15. pixel_x=640 (col 80) -> black.
- Cursor blink: CTRL=0x3_0000 at (0,0), BLINK_FRAMES=2.
  - Rows 14-15 of cell 0 show fg in frames 0-1, per-cell colours in frames 2-3, fg again in frames 4-5.
  - With blink_en=0, fg is shown in every frame.
